// File: rtl/reaction_delay_timer.sv
// Reaction-time trial controller: random foreperiod from the LFSR word, stimulus,
// then a millisecond reaction count ended by a button edge or a timeout.
module reaction_delay_timer #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned MAX_REACT_MS = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] rand_in,
  input  logic        start,
  input  logic        button,
  output logic        busy,
  output logic        stim_on,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = 15;
  localparam int unsigned RW = 14;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STIM, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [RW-1:0] react_q, react_d;
  logic          btn_q;
  logic          busy_q, busy_d;
  logic          stim_on_q, stim_on_d;
  logic [RW-1:0] result_ms_q, result_ms_d;
  logic          result_valid_q, result_valid_d;
  logic          false_start_q, false_start_d;
  logic          timeout_q, timeout_d;
  logic          btn_edge;
  logic          tick;
  logic [RW-1:0] react_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      delay_q        <= '0;
      react_q        <= '0;
      btn_q          <= 1'b0;
      busy_q         <= 1'b0;
      stim_on_q      <= 1'b0;
      result_ms_q    <= '0;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      delay_q        <= delay_d;
      react_q        <= react_d;
      btn_q          <= button;
      busy_q         <= busy_d;
      stim_on_q      <= stim_on_d;
      result_ms_q    <= result_ms_d;
      result_valid_q <= result_valid_d;
      false_start_q  <= false_start_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    react_d       = react_q;
    result_ms_d   = result_ms_q;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;
    btn_edge      = button & ~btn_q;
    tick          = (presc_q == PW'(TICK_DIV - 1));
    react_inc     = react_q + RW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_WAIT;
          delay_d       = DW'(MIN_DELAY_MS) + DW'(rand_in);
          result_ms_d   = '0;
          false_start_d = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      // A button edge on the expiring tick still counts as a false start.
      S_WAIT: begin
        if (btn_edge) begin
          state_d       = S_DONE;
          false_start_d = 1'b1;
          result_ms_d   = '0;
        end else if (tick) begin
          if (delay_q == DW'(1)) begin
            state_d = S_STIM;
            react_d = '0;
          end else begin
            delay_d = delay_q - DW'(1);
          end
        end
      end
      // Button edge reports the pre-tick count even if a tick coincides.
      S_STIM: begin
        if (btn_edge) begin
          state_d     = S_DONE;
          result_ms_d = react_q;
        end else if (tick) begin
          react_d = react_inc;
          if (react_inc == RW'(MAX_REACT_MS)) begin
            state_d     = S_DONE;
            timeout_d   = 1'b1;
            result_ms_d = RW'(MAX_REACT_MS);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Prescaler restarts on every state change so each state sees a full first tick.
    if ((state_d != state_q) || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    busy_d         = (state_d == S_WAIT) || (state_d == S_STIM);
    stim_on_d      = (state_d == S_STIM);
    result_valid_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  assign busy         = busy_q;
  assign stim_on      = stim_on_q;
  assign result_ms    = result_ms_q;
  assign result_valid = result_valid_q;
  assign false_start  = false_start_q;
  assign timeout      = timeout_q;

endmodule
